// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for the chunked two's-complement adder/subtractor.
interface serial_addsub_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, carry held between chunks,
// operands and results on valid/ready handshakes with carry/borrow, overflow and zero flags.
module serial_addsub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input logic            clk,
   input logic            rst_n,
   serial_addsub_if.slave bus
);
   localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
   localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("serial_addsub: WIDTH must be at least 2");
      end
      if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("serial_addsub: CHUNK must divide WIDTH exactly");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [CHUNK:0]   chunk_add;
   logic [WIDTH-1:0] acc_next;
   logic             last_chunk;
   logic             chunk_ovf;

   // Operand registers shift right so the active chunk always sits in the low CHUNK bits;
   // partial sums enter the accumulator from the top.
   assign chunk_add  = (CHUNK+1)'(a_q[CHUNK-1:0]) + (CHUNK+1)'(b_q[CHUNK-1:0]) + (CHUNK+1)'(carry_q);
   assign acc_next   = WIDTH'({chunk_add[CHUNK-1:0], acc_q} >> CHUNK);
   assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));
   assign chunk_ovf  = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (chunk_add[CHUNK-1] != a_q[CHUNK-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               // Subtraction is A + ~B + 1: invert B now, inject the +1 as the initial carry.
               a_d        = bus.a;
               b_d        = bus.b ^ {WIDTH{bus.sub}};
               carry_d    = bus.sub;
               idx_d      = '0;
               acc_d      = '0;
               in_ready_d = 1'b0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = chunk_add[CHUNK];
            acc_d   = acc_next;
            idx_d   = idx_q + IDXW'(1);
            if (last_chunk) begin
               sum_d       = acc_next;
               cout_d      = chunk_add[CHUNK];
               ovf_d       = chunk_ovf;
               zero_d      = ~|acc_next;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule
